// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the MEM-stage data memory responder.
package mem_resp_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned VEC_BYTES  = 16;
    localparam int unsigned VEC_WIDTH  = VEC_BYTES * DATA_W;
    localparam int unsigned BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        VEC_BURST,
        DONE
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the MEM stage and the data memory responder.
interface data_memory_responder_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    import mem_resp_pkg::*;

    logic                  req_valid;
    logic                  req_write;
    logic                  req_vector;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_W-1:0]     wdata;
    logic [VEC_WIDTH-1:0]  vector_wdata;
    logic [DATA_W-1:0]     rdata;
    logic [VEC_WIDTH-1:0]  vector_rdata;
    logic                  resp_valid;
    logic                  stall;

    modport master (
        output req_valid, req_write, req_vector, req_addr, wdata, vector_wdata,
        input  rdata, vector_rdata, resp_valid, stall
    );

    modport slave (
        input  req_valid, req_write, req_vector, req_addr, wdata, vector_wdata,
        output rdata, vector_rdata, resp_valid, stall
    );

endinterface

// File: rtl/byte_ram.sv
// Byte-wide single-port RAM: synchronous write, one-cycle registered read.
module byte_ram #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [0:DEPTH-1];

    // Write has priority; a read only updates the output register when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage responder: single-cycle scalar accesses, 16-beat serialized vector accesses.
module data_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(VEC_BYTES - 1);

    state_t                  state;
    logic [BEAT_CNT_W-1:0]   beat;
    logic [ADDR_WIDTH-1:0]   base;
    logic [VEC_WIDTH-1:0]    wbuf;
    logic [VEC_WIDTH-1:0]    vec_buf;
    logic                    vec_write;
    logic [VEC_WIDTH-1:0]    vector_rdata;
    logic                    resp_valid;
    logic [DATA_W-1:0]       rdata_hold;
    logic                    scalar_fresh;

    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;

    byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Stall covers the accepting IDLE cycle plus the whole burst; forced low in reset.
    assign bus.stall = !reset &&
                       (((state == IDLE) && bus.req_valid && bus.req_vector) ||
                        (state == VEC_BURST));

    // Right after a scalar load the RAM output register is the fresh result;
    // afterwards the held copy is shown so vector beats cannot disturb it.
    assign bus.rdata        = scalar_fresh ? ram_rdata : rdata_hold;
    assign bus.vector_rdata = vector_rdata;
    assign bus.resp_valid   = resp_valid;

    // RAM port steering; load beats are prefetched one cycle ahead to cover read latency.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = bus.req_addr;
        ram_wdata = bus.wdata;
        if (state == IDLE) begin
            if (bus.req_valid) begin
                ram_we = bus.req_write && !bus.req_vector;
                ram_re = !bus.req_write;
            end
        end else if (state == VEC_BURST) begin
            if (vec_write) begin
                ram_we    = 1'b1;
                ram_addr  = base + ADDR_WIDTH'(beat);
                ram_wdata = wbuf[{beat, 3'b000} +: 8];
            end else begin
                ram_re   = (beat != LAST_BEAT);
                ram_addr = base + ADDR_WIDTH'(beat) + ADDR_WIDTH'(1);
            end
        end
        if (reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // Control FSM with registered responses and load-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            beat         <= '0;
            base         <= '0;
            wbuf         <= '0;
            vec_buf      <= '0;
            vec_write    <= 1'b0;
            vector_rdata <= '0;
            resp_valid   <= 1'b0;
            rdata_hold   <= '0;
            scalar_fresh <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            scalar_fresh <= 1'b0;
            if (scalar_fresh) begin
                rdata_hold <= ram_rdata;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_vector) begin
                            state     <= VEC_BURST;
                            beat      <= '0;
                            base      <= bus.req_addr;
                            wbuf      <= bus.vector_wdata;
                            vec_write <= bus.req_write;
                        end else begin
                            resp_valid   <= 1'b1;
                            scalar_fresh <= !bus.req_write;
                        end
                    end
                end
                VEC_BURST: begin
                    if (!vec_write) begin
                        vec_buf[{beat, 3'b000} +: 8] <= ram_rdata;
                    end
                    if (beat == LAST_BEAT) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        if (!vec_write) begin
                            vector_rdata <= {ram_rdata, vec_buf[VEC_WIDTH-DATA_W-1:0]};
                        end
                    end else begin
                        beat <= beat + BEAT_CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
